// File: rtl/controlador_varredura_display.sv
// Display scan sequencer for the coffee machine: registers the one-hot machine state, blanks the
// display for a few frames after every state change and then scans the four digit anodes.
module controlador_varredura_display #(
  parameter int unsigned DIV_MAX      = 50000,
  parameter int unsigned BLANK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       S0,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       SR,
  input  logic       SP,
  input  logic       SN,
  input  logic       VL,
  output logic       saida1Contador,
  output logic       saida2Contador,
  output logic [3:0] anodo,
  output logic       display_ativo,
  output logic       erro_estado,
  output logic       troca_estado
);

  localparam int unsigned PW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned QW = $clog2(BLANK_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_MAX   = PW'(DIV_MAX - 1);
  localparam logic [QW-1:0] QUADROS_INI = QW'(BLANK_FRAMES);

  typedef enum logic [1:0] {StOcioso, StBranco, StVarredura, StErro} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [7:0]    estado_reg, estado_ant;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [1:0]    contador_q, contador_d;
  logic [QW-1:0] quadros_q, quadros_d;
  logic          valido, zero, troca, tick, erro_d;

  assign valido = $onehot(estado_reg);
  assign zero   = (estado_reg == 8'h00);
  assign troca  = (estado_reg != estado_ant);
  assign tick   = (prescaler_q == PRESC_MAX);

  // Prescaler and digit counter restart together on a change so blanking lasts whole frames.
  always_comb begin
    prescaler_d = prescaler_q + PW'(1);
    if (troca || tick) begin
      prescaler_d = '0;
    end
    contador_d = contador_q;
    if (valido) begin
      if (troca) begin
        contador_d = 2'b00;
      end else if (tick) begin
        contador_d = contador_q + 2'b01;
      end
    end
  end

  // Priority inside each state: invalid > change > tick.
  always_comb begin
    fsm_d     = fsm_q;
    quadros_d = quadros_q;
    case (fsm_q)
      StOcioso: begin
        if (valido) begin
          fsm_d     = StBranco;
          quadros_d = QUADROS_INI;
        end else if (!zero) begin
          fsm_d = StErro;
        end
      end
      StBranco: begin
        if (!valido) begin
          fsm_d = StErro;
        end else if (troca) begin
          quadros_d = QUADROS_INI;
        end else if (tick && (contador_q == 2'b11)) begin
          quadros_d = quadros_q - QW'(1);
          if (quadros_q == QW'(1)) begin
            fsm_d = StVarredura;
          end
        end
      end
      StVarredura: begin
        if (zero) begin
          fsm_d = StOcioso;
        end else if (!valido) begin
          fsm_d = StErro;
        end else if (troca) begin
          fsm_d     = StBranco;
          quadros_d = QUADROS_INI;
        end
      end
      StErro: begin
        if (zero) begin
          fsm_d = StOcioso;
        end else if (valido) begin
          fsm_d     = StBranco;
          quadros_d = QUADROS_INI;
        end
      end
      default: fsm_d = StOcioso;
    endcase
  end

  // An empty state word while idle is normal, not an error.
  assign erro_d = ~valido & ~((fsm_d == StOcioso) & zero);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_reg    <= 8'h00;
      estado_ant    <= 8'h00;
      prescaler_q   <= '0;
      contador_q    <= 2'b00;
      quadros_q     <= '0;
      fsm_q         <= StOcioso;
      anodo         <= 4'b1111;
      display_ativo <= 1'b0;
      erro_estado   <= 1'b0;
      troca_estado  <= 1'b0;
    end else begin
      estado_reg    <= {S0, S1, S2, S3, SR, SP, SN, VL};
      estado_ant    <= estado_reg;
      prescaler_q   <= prescaler_d;
      contador_q    <= contador_d;
      quadros_q     <= quadros_d;
      fsm_q         <= fsm_d;
      anodo         <= (fsm_d == StVarredura) ? ~(4'b0001 << contador_d) : 4'b1111;
      display_ativo <= (fsm_d == StVarredura);
      erro_estado   <= erro_d;
      troca_estado  <= troca;
    end
  end

  assign saida1Contador = contador_q[1];
  assign saida2Contador = contador_q[0];

endmodule

// File: tb/tb_controlador_varredura_display.sv
// Bench for controlador_varredura_display: directed scenarios with literal expectations, then
// random state sequences checked every cycle against a timing model of the display.
module tb_controlador_varredura_display;

  localparam int DIV = 4;
  localparam int BLK = 1;
  localparam int BL  = BLK * 4 * DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ins   = 8'h00;
  logic       saida1Contador, saida2Contador, display_ativo, erro_estado, troca_estado;
  logic [3:0] anodo;

  controlador_varredura_display #(.DIV_MAX(DIV), .BLANK_FRAMES(BLK)) dut (
    .clock          (clock),
    .reset          (reset),
    .S0             (ins[7]),
    .S1             (ins[6]),
    .S2             (ins[5]),
    .S3             (ins[4]),
    .SR             (ins[3]),
    .SP             (ins[2]),
    .SN             (ins[1]),
    .VL             (ins[0]),
    .saida1Contador (saida1Contador),
    .saida2Contador (saida2Contador),
    .anodo          (anodo),
    .display_ativo  (display_ativo),
    .erro_estado    (erro_estado),
    .troca_estado   (troca_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 active (blank then scan, decided by time since last valid change t0),
  // 2 error. The counter is (cycles since t0)/DIV mod 4 while the state word is valid.
  logic [7:0] m_reg = 8'h00, m_ant = 8'h00;
  int         mode = 0, t0 = 0, cyc = 0, m_cnt = 0, c_n = 0;
  logic       m_troca = 1'b0, chg_n, was_scan;

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_reg = 8'h00; m_ant = 8'h00; mode = 0; t0 = 0; cyc = 0; m_cnt = 0; m_troca = 1'b0;
      end else begin
        c_n      = cyc + 1;
        chg_n    = (m_reg != m_ant);
        was_scan = (mode == 1) && (cyc >= t0 + BL);
        if (m_reg == 8'h00) begin
          mode = (mode == 1 && !was_scan) ? 2 : 0;
        end else if ($countones(m_reg) != 1) begin
          mode = 2;
        end else begin
          if (chg_n || mode != 1) t0 = c_n;
          mode  = 1;
          m_cnt = ((c_n - t0) / DIV) % 4;
        end
        m_troca = chg_n;
        m_ant   = m_reg;
        m_reg   = ins;
        cyc     = c_n;
      end
    end
  end

  logic       e_scan;
  logic [1:0] e_cnt;
  logic [3:0] e_an;

  initial begin
    forever begin
      @(negedge clock);
      e_scan = (mode == 1) && (cyc >= t0 + BL);
      e_cnt  = 2'(m_cnt);
      e_an   = e_scan ? ~(4'b0001 << e_cnt) : 4'hF;
      chk("model_cnt", 32'({saida1Contador, saida2Contador}), 32'(e_cnt));
      chk("model_anodo", 32'(anodo), 32'(e_an));
      chk("model_ativo", 32'(display_ativo), 32'(e_scan));
      chk("model_erro", 32'(erro_estado), 32'(mode == 2));
      chk("model_troca", 32'(troca_estado), 32'(m_troca));
    end
  end

  task automatic wn(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic lit(input string nm, input logic [3:0] an, input logic [1:0] cnt);
    chk({nm, "_anodo"}, 32'(anodo), 32'(an));
    chk({nm, "_cnt"}, 32'({saida1Contador, saida2Contador}), 32'(cnt));
  endtask

  int h;
  int r;

  initial begin
    wn(3);
    reset = 1'b0;
    lit("reset", 4'hF, 2'd0);
    chk("reset_erro", 32'(erro_estado), 0);
    chk("reset_troca", 32'(troca_estado), 0);
    wn(1); ins = 8'h80;                                      // N0: S0
    wn(1); chk("s0_troca_early", 32'(troca_estado), 0);
    wn(1); chk("s0_troca", 32'(troca_estado), 1); lit("s0_blank0", 4'hF, 2'd0);
    wn(15); lit("s0_blank_last", 4'hF, 2'd3);
    wn(1); lit("s0_scan0", 4'hE, 2'd0); chk("s0_ativo", 32'(display_ativo), 1);
    wn(4); lit("s0_scan1", 4'hD, 2'd1);
    wn(4); lit("s0_scan2", 4'hB, 2'd2);
    wn(1); ins = 8'h40;                                      // N27: S1 mid-scan
    wn(2); chk("s1_troca", 32'(troca_estado), 1); lit("s1_reset", 4'hF, 2'd0);
    wn(15); lit("s1_blank_last", 4'hF, 2'd3);
    wn(1); lit("s1_scan0", 4'hE, 2'd0);
    wn(6); ins = 8'hA0;                                      // N51: S0|S2
    wn(1); chk("inv_erro_early", 32'(erro_estado), 0);
    wn(1); chk("inv_erro", 32'(erro_estado), 1); lit("inv", 4'hF, 2'd1);
    wn(3); lit("inv_frozen", 4'hF, 2'd1);
    wn(1); ins = 8'h20;                                      // N57: S2 alone
    wn(2); chk("rec_troca", 32'(troca_estado), 1); chk("rec_erro", 32'(erro_estado), 0);
    wn(15); lit("rec_blank_last", 4'hF, 2'd3);
    wn(1); lit("rec_scan0", 4'hE, 2'd0);
    wn(14); lit("s3_before", 4'h7, 2'd3); ins = 8'h10;      // N89: change on tick at 11
    wn(2); lit("s3_troca", 4'hF, 2'd0);
    wn(14); lit("sr_before", 4'hF, 2'd3); ins = 8'h08;      // N105: change on last blank tick
    wn(2); lit("sr_reload", 4'hF, 2'd0); chk("sr_troca", 32'(troca_estado), 1);
    wn(15); lit("sr_blank_last", 4'hF, 2'd3);
    wn(1); lit("sr_scan0", 4'hE, 2'd0);
    wn(9); lit("pre_rst", 4'hB, 2'd2);
    #2 reset = 1'b1;
    #1 lit("async_rst", 4'hF, 2'd0); chk("async_rst_ativo", 32'(display_ativo), 0);
    ins = 8'h00;
    wn(2); reset = 1'b0;
    wn(3); lit("idle", 4'hF, 2'd0); chk("idle_erro", 32'(erro_estado), 0);
    ins = 8'h80;
    wn(2 + BL); lit("idle_scan", 4'hE, 2'd0);
    ins = 8'h00;
    wn(2); lit("zero", 4'hF, 2'd0);
    chk("zero_ativo", 32'(display_ativo), 0); chk("zero_erro", 32'(erro_estado), 0);
    wn(3); chk("zero_erro_late", 32'(erro_estado), 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      h = (r < 6) ? $urandom_range(1, 8) : $urandom_range(10, 40);
      if (r < 12) begin
        ins = 8'h01 << $urandom_range(0, 7);
      end else if (r < 14) begin
        ins = 8'h00;
      end else if (r < 18) begin
        ins = 8'($urandom);
      end else begin
        #($urandom_range(1, 4)) reset = 1'b1;
        wn(1);
        reset = 1'b0;
      end
      wn(h);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
